// File: rtl/hub75_pkg.sv
// -----------------------------------------------------------------------------
// hub75_pkg
// Shared types and constants for the HUB75 scan controller.
//   state_e      : scan controller FSM states
//   C_R0..C_B1   : bit positions of each colour line inside a 6-bit pixel slice
//   COLOUR_BITS  : width of one pixel slice ({B1,G1,R1,B0,G0,R0})
//   disp_len()   : number of display cycles for a given bit plane
// -----------------------------------------------------------------------------
package hub75_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SHIFT   = 3'd1,
        ST_BLANK   = 3'd2,
        ST_LATCH   = 3'd3,
        ST_DISPLAY = 3'd4
    } state_e;

    localparam int unsigned C_R0        = 32'd0;
    localparam int unsigned C_G0        = 32'd1;
    localparam int unsigned C_B0        = 32'd2;
    localparam int unsigned C_R1        = 32'd3;
    localparam int unsigned C_G1        = 32'd4;
    localparam int unsigned C_B1        = 32'd5;
    localparam int unsigned COLOUR_BITS = 32'd6;

    // Binary-code modulation: each plane is shown twice as long as the one below.
    function automatic int unsigned disp_len(input int unsigned base_on,
                                             input int unsigned plane);
        return base_on << plane;
    endfunction

endpackage

// File: rtl/hub75_scan_ctrl_bcm_timer.sv
// -----------------------------------------------------------------------------
// bcm_timer
// Loadable down-counter that times one bit-plane display window.
//   clk_i      : clock
//   rst_i      : synchronous active-high reset (counter cleared)
//   load_i     : load load_val_i (takes priority over dec_i)
//   load_val_i : value to load, window length minus one
//   dec_i      : decrement by one (saturates at zero)
//   done_o     : counter is zero, i.e. this is the last cycle of the window
// -----------------------------------------------------------------------------
module bcm_timer #(
    parameter int unsigned W = 7
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         done_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: load has priority, decrement stops at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q == '0);

endmodule

// File: rtl/hub75_scan_ctrl.sv
// -----------------------------------------------------------------------------
// hub75_scan_ctrl
// Scan controller for a 1/16-scan HUB75 RGB panel with two half-panels.
// For every (row, plane) it reads one column pair per two cycles from the
// framebuffer, shifts it into the panel, blanks, latches, then enables the
// LEDs for a plane-weighted number of cycles (binary-code modulation).
// Ports:
//   CLK_I, RST_I        : clock, synchronous active-high reset
//   EN_I                : run enable (sampled in IDLE and last display cycle)
//   FB_RD_O, FB_ADDR_O  : framebuffer read strobe and {row, col} address
//   FB_DATA_I           : read data one cycle after FB_RD_O, 6 bits per plane
//   R0,G0,B0,R1,G1,B1   : registered colour data to the panel
//   CLK_O, LATCH, OE    : panel shift clock, latch (high), output enable (low)
//   RA,RB,RC,RD         : row address bits 0..3
//   FRAME_O             : one-cycle pulse on the first shift of a new frame
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module hub75_scan_ctrl
    import hub75_pkg::*;
#(
    parameter int unsigned COLS    = 32,
    parameter int unsigned ROWS    = 16,
    parameter int unsigned PLANES  = 4,
    parameter int unsigned BASE_ON = 8
) (
    input  logic                                  CLK_I,
    input  logic                                  RST_I,
    input  logic                                  EN_I,
    output logic                                  FB_RD_O,
    output logic [$clog2(ROWS)+$clog2(COLS)-1:0]  FB_ADDR_O,
    input  logic [6*PLANES-1:0]                   FB_DATA_I,
    output logic                                  R0,
    output logic                                  G0,
    output logic                                  B0,
    output logic                                  R1,
    output logic                                  G1,
    output logic                                  B1,
    output logic                                  CLK_O,
    output logic                                  LATCH,
    output logic                                  OE,
    output logic                                  RA,
    output logic                                  RB,
    output logic                                  RC,
    output logic                                  RD,
    output logic                                  FRAME_O
);

    localparam int unsigned RW = $clog2(ROWS);
    localparam int unsigned CW = $clog2(COLS);
    localparam int unsigned AW = RW + CW;
    localparam int unsigned KW = $clog2(2 * COLS + 2);
    localparam int unsigned PW = (PLANES > 1) ? $clog2(PLANES) : 1;
    localparam int unsigned TW = $clog2(BASE_ON << (PLANES - 1)) + 1;

    localparam logic [KW-1:0] K_LAST     = KW'(2 * COLS + 1);
    localparam logic [KW-1:0] K_RD_END   = KW'(2 * COLS);
    localparam logic [KW-1:0] K_CLK_1ST  = KW'(3);
    localparam logic [RW-1:0] ROW_LAST   = RW'(ROWS - 1);
    localparam logic [PW-1:0] PLANE_LAST = PW'(PLANES - 1);

    // Control state
    state_e          state_q, state_d;
    logic [KW-1:0]   k_q, k_d;
    logic [RW-1:0]   row_q, row_d;
    logic [PW-1:0]   plane_q, plane_d;

    // Output registers
    logic            fb_rd_q, fb_rd_d;
    logic [AW-1:0]   fb_addr_q, fb_addr_d;
    logic [5:0]      colour_q, colour_d;
    logic            sclk_q, sclk_d;
    logic            latch_q, latch_d;
    logic            oe_q, oe_d;
    logic [3:0]      row_addr_q, row_addr_d;
    logic            frame_q, frame_d;

    // Combinational helpers
    logic            tmr_load_s;
    logic            tmr_dec_s;
    logic            tmr_done_s;
    logic [TW-1:0]   tmr_val_s;
    logic [5:0]      plane_bits_s;
    logic            shift_next_s;

    assign tmr_val_s    = TW'(disp_len(BASE_ON, 32'(plane_q)) - 32'd1);
    assign plane_bits_s = FB_DATA_I[COLOUR_BITS * 32'(plane_q) +: COLOUR_BITS];

    bcm_timer #(
        .W (TW)
    ) u_bcm_timer (
        .clk_i      (CLK_I),
        .rst_i      (RST_I),
        .load_i     (tmr_load_s),
        .load_val_i (tmr_val_s),
        .dec_i      (tmr_dec_s),
        .done_o     (tmr_done_s)
    );

    // FSM next state, column/row/plane counters and display-timer control.
    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        row_d      = row_q;
        plane_d    = plane_q;
        frame_d    = 1'b0;
        tmr_load_s = 1'b0;
        tmr_dec_s  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (EN_I) begin
                    state_d = ST_SHIFT;
                    k_d     = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (k_q == K_LAST) begin
                    state_d = ST_BLANK;
                    k_d     = '0;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            ST_BLANK: begin
                state_d = ST_LATCH;
            end
            ST_LATCH: begin
                state_d    = ST_DISPLAY;
                tmr_load_s = 1'b1;
            end
            ST_DISPLAY: begin
                if (tmr_done_s) begin
                    // Plane loop is inner, row loop outer.
                    if (plane_q == PLANE_LAST) begin
                        plane_d = '0;
                        if (row_q == ROW_LAST) begin
                            row_d   = '0;
                            frame_d = 1'b1;
                        end else begin
                            row_d = row_q + RW'(1);
                        end
                    end else begin
                        plane_d = plane_q + PW'(1);
                    end
                    if (EN_I) begin
                        state_d = ST_SHIFT;
                        k_d     = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    tmr_dec_s = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                k_d     = '0;
            end
        endcase
    end

    // Pin values for the next cycle, derived from the next state so that
    // every pin is a flop yet lines up with the cycle it describes.
    always_comb begin
        shift_next_s = (state_d == ST_SHIFT);
        fb_rd_d      = shift_next_s && !k_d[0] && (k_d < K_RD_END);
        if (fb_rd_d) begin
            fb_addr_d = {row_d, k_d[CW:1]};
        end else begin
            fb_addr_d = fb_addr_q;
        end
        // Rising CLK_O lands one cycle after the column's data is on the pins.
        sclk_d = shift_next_s && k_d[0] && (k_d >= K_CLK_1ST);
        // Read data arrives on odd cycles; capture it for the current plane.
        if ((state_q == ST_SHIFT) && k_q[0] && (k_q < K_RD_END)) begin
            colour_d = plane_bits_s;
        end else begin
            colour_d = colour_q;
        end
        latch_d = (state_d == ST_LATCH);
        oe_d    = (state_d != ST_DISPLAY);
        if (latch_d) begin
            row_addr_d = 4'(row_d);
        end else begin
            row_addr_d = row_addr_q;
        end
    end

    // State, counters and output registers with synchronous reset.
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            state_q    <= ST_IDLE;
            k_q        <= '0;
            row_q      <= '0;
            plane_q    <= '0;
            fb_rd_q    <= 1'b0;
            fb_addr_q  <= '0;
            colour_q   <= 6'd0;
            sclk_q     <= 1'b0;
            latch_q    <= 1'b0;
            oe_q       <= 1'b1;
            row_addr_q <= 4'd0;
            frame_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            row_q      <= row_d;
            plane_q    <= plane_d;
            fb_rd_q    <= fb_rd_d;
            fb_addr_q  <= fb_addr_d;
            colour_q   <= colour_d;
            sclk_q     <= sclk_d;
            latch_q    <= latch_d;
            oe_q       <= oe_d;
            row_addr_q <= row_addr_d;
            frame_q    <= frame_d;
        end
    end

    assign FB_RD_O   = fb_rd_q;
    assign FB_ADDR_O = fb_addr_q;
    assign R0        = colour_q[C_R0];
    assign G0        = colour_q[C_G0];
    assign B0        = colour_q[C_B0];
    assign R1        = colour_q[C_R1];
    assign G1        = colour_q[C_G1];
    assign B1        = colour_q[C_B1];
    assign CLK_O     = sclk_q;
    assign LATCH     = latch_q;
    assign OE        = oe_q;
    assign RA        = row_addr_q[0];
    assign RB        = row_addr_q[1];
    assign RC        = row_addr_q[2];
    assign RD        = row_addr_q[3];
    assign FRAME_O   = frame_q;

endmodule

// File: tb/tb_hub75_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hub75_scan_ctrl
// Self-checking bench: a framebuffer memory model feeds the controller, and a
// plane-position model (cycle offset t inside the current row/plane window)
// predicts every pin each cycle. Literal checks pin reset values, pixel data
// at the first/last shift edge, edge/read counts and OE run lengths.
// -----------------------------------------------------------------------------
module tb_hub75_scan_ctrl;

    localparam int COLS    = 32;
    localparam int ROWS    = 16;
    localparam int PLANES  = 4;
    localparam int BASE_ON = 8;
    localparam int AW      = 9;
    localparam int SH      = 2 * COLS + 2;

    logic          CLK_I = 1'b0;
    logic          RST_I = 1'b1;
    logic          EN_I  = 1'b0;
    logic          FB_RD_O;
    logic [AW-1:0] FB_ADDR_O;
    logic [23:0]   FB_DATA_I;
    logic          R0, G0, B0, R1, G1, B1;
    logic          CLK_O, LATCH, OE;
    logic          RA, RB, RC, RD;
    logic          FRAME_O;

    logic [23:0]   mem [ROWS*COLS];

    hub75_scan_ctrl #(
        .COLS(COLS), .ROWS(ROWS), .PLANES(PLANES), .BASE_ON(BASE_ON)
    ) dut (
        .CLK_I(CLK_I), .RST_I(RST_I), .EN_I(EN_I),
        .FB_RD_O(FB_RD_O), .FB_ADDR_O(FB_ADDR_O), .FB_DATA_I(FB_DATA_I),
        .R0(R0), .G0(G0), .B0(B0), .R1(R1), .G1(G1), .B1(B1),
        .CLK_O(CLK_O), .LATCH(LATCH), .OE(OE),
        .RA(RA), .RB(RB), .RC(RC), .RD(RD), .FRAME_O(FRAME_O)
    );

    always #5 CLK_I = ~CLK_I;

    // Framebuffer RAM: one-cycle read latency, garbage when not reading.
    always @(posedge CLK_I) begin
        FB_DATA_I <= FB_RD_O ? mem[FB_ADDR_O] : 24'($urandom);
    end

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model state
    bit         m_run;
    int         m_t, m_row, m_plane;
    logic [5:0] m_col;
    logic [3:0] m_ra;
    bit         m_frame;

    // Literal trackers
    int rise_cnt, rd_cnt, oe_run, run_idx, frame_cnt;
    bit cnt_valid, prev_clk;
    int exp_runs [4] = '{8, 16, 32, 64};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic int plen(input int p);
        return 2 * COLS + 4 + (BASE_ON << p);
    endfunction

    task automatic model_step(input logic en, input logic rst);
        if (rst) begin
            m_run = 0; m_t = 0; m_row = 0; m_plane = 0;
            m_col = 6'd0; m_ra = 4'd0; m_frame = 0;
        end else begin
            m_frame = 0;
            if (!m_run) begin
                if (en) begin
                    m_run = 1;
                    m_t   = 0;
                end
            end else if (m_t == plen(m_plane) - 1) begin
                if (m_plane == PLANES - 1) begin
                    m_plane = 0;
                    if (m_row == ROWS - 1) begin
                        m_row   = 0;
                        m_frame = 1;
                    end else begin
                        m_row++;
                    end
                end else begin
                    m_plane++;
                end
                if (en) m_t = 0;
                else    m_run = 0;
            end else begin
                m_t++;
            end
            if (m_run && m_t == SH + 1) m_ra = 4'(m_row);
            if (m_run && m_t >= 2 && m_t <= SH - 1)
                m_col = mem[m_row * COLS + (m_t - 2) / 2][6 * m_plane +: 6];
        end
    endtask

    task automatic compare();
        bit exp_rd;
        exp_rd = m_run && (m_t < 2 * COLS) && (m_t % 2 == 0);
        check("fb_rd", 32'(FB_RD_O), 32'(exp_rd));
        if (exp_rd) check("fb_addr", 32'(FB_ADDR_O), 32'(m_row * COLS + m_t / 2));
        check("clk_o", 32'(CLK_O), 32'(m_run && m_t < SH && (m_t % 2 == 1) && m_t >= 3));
        check("latch", 32'(LATCH), 32'(m_run && m_t == SH + 1));
        check("oe", 32'(OE), 32'(!(m_run && m_t >= SH + 2)));
        check("frame", 32'(FRAME_O), 32'(m_frame));
        check("colour", 32'({B1, G1, R1, B0, G0, R0}), 32'(m_col));
        check("row_addr", 32'({RD, RC, RB, RA}), 32'(m_ra));
        check("latch_oe_excl", 32'(LATCH & ~OE), 32'd0);
    endtask

    task automatic track(input logic rst);
        if (rst) begin
            oe_run = 0; run_idx = 0; cnt_valid = 0; prev_clk = 0;
        end else begin
            if (m_run && m_t == 0) begin
                rise_cnt = 0; rd_cnt = 0; cnt_valid = 1;
            end
            if (FB_RD_O) rd_cnt++;
            if (CLK_O && !prev_clk) begin
                if (cnt_valid && m_plane == 0 && rise_cnt == 0)
                    check("col0_pixels", 32'({B1, G1, R1, B0, G0, R0}), 32'h2A);
                if (cnt_valid && m_plane == 0 && rise_cnt == COLS - 1)
                    check("col31_pixels", 32'({B1, G1, R1, B0, G0, R0}), 32'h15);
                rise_cnt++;
            end
            prev_clk = CLK_O;
            if (LATCH && cnt_valid) begin
                check("clk_rises", 32'(rise_cnt), 32'd32);
                check("rd_count", 32'(rd_cnt), 32'd32);
                cnt_valid = 0;
            end
            if (!OE) begin
                oe_run++;
            end else if (oe_run > 0) begin
                check("oe_run_len", 32'(oe_run), 32'(exp_runs[run_idx]));
                run_idx = (run_idx + 1) % 4;
                oe_run  = 0;
            end
            if (FRAME_O) frame_cnt++;
        end
    endtask

    task automatic step(input logic en, input logic rst);
        EN_I  = en;
        RST_I = rst;
        @(posedge CLK_I);
        model_step(en, rst);
        @(negedge CLK_I);
        compare();
        track(rst);
    endtask

    initial begin
        int  guard;
        bit  en_r;
        for (int i = 0; i < ROWS * COLS; i++) mem[i] = 24'($urandom);
        for (int r = 0; r < ROWS; r++) begin
            mem[r * COLS]            = 24'h00002A;
            mem[r * COLS + COLS - 1] = 24'h000015;
        end
        run_idx = 0; oe_run = 0; frame_cnt = 0;

        // Reset held for three cycles, then literal reset values.
        repeat (3) step(1'b0, 1'b1);
        check("rst_oe", 32'(OE), 32'd1);
        check("rst_latch", 32'(LATCH), 32'd0);
        check("rst_clk", 32'(CLK_O), 32'd0);
        check("rst_rd", 32'(FB_RD_O), 32'd0);
        check("rst_frame", 32'(FRAME_O), 32'd0);
        check("rst_colour", 32'({B1, G1, R1, B0, G0, R0}), 32'd0);
        check("rst_row", 32'({RD, RC, RB, RA}), 32'd0);
        repeat (4) step(1'b0, 1'b0);

        // One full frame and a bit with enable held high.
        frame_cnt = 0;
        repeat (6400) step(1'b1, 1'b0);
        check("frame_count", 32'(frame_cnt), 32'd1);

        // Run to row 5 plane 2 mid-shift, then drop enable.
        guard = 0;
        while (!(m_run && m_row == 5 && m_plane == 2 && m_t == 10) && guard < 8000) begin
            step(1'b1, 1'b0);
            guard++;
        end
        check("reach_r5p2", 32'(guard < 8000), 32'd1);
        guard = 0;
        while (m_run && guard < 400) begin
            step(1'b0, 1'b0);
            guard++;
        end
        check("drop_en_idle_bound", 32'(guard < 400), 32'd1);
        repeat (10) step(1'b0, 1'b0);
        check("idle_oe", 32'(OE), 32'd1);

        // Resume: must continue at row 5 (plane 3, 64-cycle run).
        guard = 0;
        while (!LATCH && guard < 100) begin
            step(1'b1, 1'b0);
            guard++;
        end
        check("resume_latch_bound", 32'(guard < 100), 32'd1);
        check("resume_row", 32'({RD, RC, RB, RA}), 32'd5);
        check("resume_plane_idx", 32'(run_idx), 32'd3);
        repeat (300) step(1'b1, 1'b0);

        // Reset in the middle of a display window.
        guard = 0;
        while (OE && guard < 200) begin
            step(1'b1, 1'b0);
            guard++;
        end
        check("reach_display", 32'(guard < 200), 32'd1);
        repeat (3) step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        check("rst_mid_oe", 32'(OE), 32'd1);
        check("rst_mid_latch", 32'(LATCH), 32'd0);
        repeat (3) step(1'b0, 1'b0);
        check("rst_mid_idle_rd", 32'(FB_RD_O), 32'd0);
        check("rst_mid_idle_oe", 32'(OE), 32'd1);

        // Randomised enable toggling with rare resets.
        en_r = 1'b1;
        for (int i = 0; i < 5000; i++) begin
            if ($urandom_range(0, 199) == 0) en_r = ~en_r;
            step(en_r, ($urandom_range(0, 1499) == 0) ? 1'b1 : 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
